// File: rtl/nios2_rom_arbiter_if.sv
// Master-side command/response bus into the ROM arbiter: command stalled by waitrequest,
// read data returned later with a one-cycle readdatavalid pulse.
interface nios2_rom_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16,
  parameter int BE_W   = 2
);
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic [BE_W-1:0]   byteenable;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport master (
    output address, read, write, writedata, byteenable,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/nios2_rom_arbiter.sv
// Two-master round-robin arbiter sharing one single-port ROM (registered address, raw q).
// Latency: read accepted at edge T returns readdatavalid in the cycle after T+1; 1 read per 2 cycles.
// Backpressure: waitrequest held high except for the winner in IDLE; NIOS2_ROM_ARB_WRITE_EN enables ROM patch writes.
module nios2_rom_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16,
  parameter int BE_W   = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  nios2_rom_arbiter_if.slave  m0,
  nios2_rom_arbiter_if.slave  m1,
  output logic [ADDR_W-1:0]   rom_address,
  output logic                rom_chipselect,
  output logic                rom_write,
  output logic                rom_debugaccess,
  output logic [DATA_W-1:0]   rom_writedata,
  output logic [BE_W-1:0]     rom_byteenable,
  output logic                rom_clken,
  input  logic [DATA_W-1:0]   rom_readdata,
  output logic                illegal_write
);

  typedef enum logic {IDLE = 1'b0, RDWAIT = 1'b1} state_t;

  state_t            state_q, state_d;
  logic              last_grant_q;
  logic              owner_q;
  logic [DATA_W-1:0] rd_dat_q [2];
  logic [1:0]        rd_vld_q;

  logic req0, req1, win, win_wr, accept;

  assign req0 = m0.read | m0.write;
  assign req1 = m1.read | m1.write;

  // Contention goes to the master that did not win last time.
  always_comb begin
    win = req1;
    if (req0 && req1) win = ~last_grant_q;
  end

  // Gated by reset_n so a held request cannot reach the ROM while in reset.
  assign accept = reset_n && (state_q == IDLE) && (req0 || req1);
  assign win_wr = win ? m1.write : m0.write;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) last_grant_q <= win;
      if (accept && !win_wr) owner_q <= win;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && !win_wr) state_d = RDWAIT;
      RDWAIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m0.waitrequest  = 1'b1;
    m1.waitrequest  = 1'b1;
    rom_chipselect  = 1'b0;
    rom_write       = 1'b0;
    rom_debugaccess = 1'b0;
    rom_address     = win ? m1.address    : m0.address;
    rom_writedata   = win ? m1.writedata  : m0.writedata;
    rom_byteenable  = win ? m1.byteenable : m0.byteenable;
    if (accept) begin
      rom_chipselect = 1'b1;
      if (win) m1.waitrequest = 1'b0;
      else     m0.waitrequest = 1'b0;
`ifdef NIOS2_ROM_ARB_WRITE_EN
      rom_write       = win_wr;
      rom_debugaccess = win_wr;
`endif
    end
  end

  assign rom_clken = 1'b1;

  // ROM q is valid throughout RDWAIT; register it toward the owning master only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_dat_q[0] <= '0;
      rd_dat_q[1] <= '0;
      rd_vld_q    <= '0;
    end else begin
      rd_vld_q <= '0;
      if (state_q == RDWAIT) begin
        rd_dat_q[owner_q] <= rom_readdata;
        rd_vld_q[owner_q] <= 1'b1;
      end
    end
  end

  assign m0.readdata      = rd_dat_q[0];
  assign m1.readdata      = rd_dat_q[1];
  assign m0.readdatavalid = rd_vld_q[0];
  assign m1.readdatavalid = rd_vld_q[1];

`ifdef NIOS2_ROM_ARB_WRITE_EN
  assign illegal_write = 1'b0;
`else
  logic illegal_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                illegal_q <= 1'b0;
    else if (accept && win_wr)   illegal_q <= 1'b1;
  end

  assign illegal_write = illegal_q;
`endif

endmodule
